// File: rtl/cache_trace_driver.sv
// Cache trace driver: buffers loader trace records in a small FIFO and replays
// them to the cache model one access per clock, counting what was issued.
module cache_trace_driver #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic [31:0]      in_addr,
  input  logic             in_last,
  input  logic             start,
  input  logic             pause,
  output logic [1:0]       Access_type,
  output logic [31:0]      Hex_address,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [1:0] TYPE_RD  = 2'd0;
  localparam logic [1:0] TYPE_WR  = 2'd1;
  localparam logic [1:0] TYPE_INV = 2'd2;
  localparam logic [1:0] TYPE_NOP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [34:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  state_t           state_r;

  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        head_last_s;
  logic [1:0]  head_type_s;
  logic [31:0] head_addr_s;

  assign full_s   = (occ_r == OCC_W'(DEPTH));
  assign empty_s  = (occ_r == {OCC_W{1'b0}});
  assign in_ready = ~full_s;
  assign push_s   = in_valid & ~full_s;
  assign pop_s    = (state_r == ST_RUN) & ~pause & ~empty_s;
  assign {head_last_s, head_type_s, head_addr_s} = mem_r[rd_ptr_r];

  // Record storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_last, in_type, in_addr};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
        2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Replay FSM with registered cache-side outputs and issue counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      Access_type <= TYPE_NOP;
      Hex_address <= 32'd0;
      rd_cnt      <= {CNT_W{1'b0}};
      wr_cnt      <= {CNT_W{1'b0}};
      inv_cnt     <= {CNT_W{1'b0}};
      stall_cnt   <= {CNT_W{1'b0}};
    end else begin
      Access_type <= TYPE_NOP;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r   <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            rd_cnt    <= {CNT_W{1'b0}};
            wr_cnt    <= {CNT_W{1'b0}};
            inv_cnt   <= {CNT_W{1'b0}};
            stall_cnt <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (pop_s) begin
            Access_type <= head_type_s;
            Hex_address <= head_addr_s;
            case (head_type_s)
              TYPE_RD:  rd_cnt  <= sat_inc(rd_cnt);
              TYPE_WR:  wr_cnt  <= sat_inc(wr_cnt);
              TYPE_INV: inv_cnt <= sat_inc(inv_cnt);
              default:  ;
            endcase
            // The last record is still issued on this edge; DONE follows immediately.
            if (head_last_s) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else if (!pause) begin
            stall_cnt <= sat_inc(stall_cnt);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
